// File: rtl/spu_fetch_queue.sv
// spu_fetch_queue: instruction fetch and issue queue for the dual-issue SPU.
// Fetches aligned instruction pairs over a req/ack port, buffers them in a
// circular queue and presents the two oldest entries (plus head PC) to decode.
// Optional feature macro: SPU_FETCH_PERF_EN adds perf_empty_cnt and
// perf_redirect_cnt outputs; without it the block is functionally identical.
module spu_fetch_queue #(
    parameter int                 WIDTH    = 32,
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_ack,
    input  logic [2*WIDTH-1:0]    imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    input  logic                  issue,
    input  logic                  issue_two,
    output logic [WIDTH-1:0]      instr0,
    output logic [WIDTH-1:0]      instr1,
    output logic                  valid0,
    output logic                  valid1,
    output logic [ADDR_W-1:0]     pc0
`ifdef SPU_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_empty_cnt,
    output logic [31:0]           perf_redirect_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage and pointers
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Fetch-side state
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_q, req_d;
    logic              drop_pending_q, drop_pending_d;
    logic              skip_first_q, skip_first_d;

    // Per-cycle helpers
    logic              ack_fire_s;
    logic [1:0]        n_pop_s;
    logic [1:0]        n_wr_s;
    logic [CNT_W-1:0]  free_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;

    assign wr_ptr_nxt_s = wr_ptr_q + PTR_W'(1);
    assign rd_ptr_nxt_s = rd_ptr_q + PTR_W'(1);
    // An ack only counts while a request is actually outstanding; a stray
    // ack left over from before a reset is therefore ignored.
    assign ack_fire_s   = req_q & imem_ack;

    // Next-state: redirect flush, pop, fill and request generation
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        head_pc_d      = head_pc_q;
        fetch_addr_d   = fetch_addr_q;
        req_addr_d     = req_addr_q;
        req_d          = req_q;
        drop_pending_d = drop_pending_q;
        skip_first_d   = skip_first_q;
        n_pop_s        = 2'd0;
        n_wr_s         = 2'd0;
        free_s         = '0;

        if (redirect) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            head_pc_d      = redirect_pc & ~ADDR_W'(3);
            fetch_addr_d   = redirect_pc & ~ADDR_W'(7);
            skip_first_d   = redirect_pc[2];
            // A request still in flight returns stale data: mark it for discard.
            drop_pending_d = req_q & ~imem_ack;
        end else begin
            if (issue && (count_q != CNT_W'(0))) begin
                if (issue_two && (count_q >= CNT_W'(2))) begin
                    n_pop_s = 2'd2;
                end else begin
                    n_pop_s = 2'd1;
                end
            end else begin
                n_pop_s = 2'd0;
            end

            if (ack_fire_s && !drop_pending_q) begin
                if (skip_first_q) begin
                    // Redirect landed on the odd word: keep only the upper one.
                    mem_d[wr_ptr_q] = imem_rdata[WIDTH-1:0];
                    n_wr_s          = 2'd1;
                    skip_first_d    = 1'b0;
                end else begin
                    mem_d[wr_ptr_q]     = imem_rdata[2*WIDTH-1:WIDTH];
                    mem_d[wr_ptr_nxt_s] = imem_rdata[WIDTH-1:0];
                    n_wr_s              = 2'd2;
                end
                fetch_addr_d = fetch_addr_q + ADDR_W'(8);
            end else begin
                n_wr_s = 2'd0;
            end

            drop_pending_d = drop_pending_q & ~ack_fire_s;
            rd_ptr_d       = rd_ptr_q + PTR_W'(n_pop_s);
            wr_ptr_d       = wr_ptr_q + PTR_W'(n_wr_s);
            count_d        = count_q + CNT_W'(n_wr_s) - CNT_W'(n_pop_s);
            head_pc_d      = head_pc_q + ADDR_W'({n_pop_s, 2'b00});
        end

        free_s = CNT_W'(DEPTH) - count_d;

        // A new request may start only when none is pending (or it completes
        // now); an unacked request is held with its original address.
        if (!req_q || ack_fire_s) begin
            if ((free_s >= CNT_W'(2)) && !drop_pending_d) begin
                req_d      = 1'b1;
                req_addr_d = fetch_addr_d;
            end else begin
                req_d      = 1'b0;
            end
        end else begin
            req_d = 1'b1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            head_pc_q      <= RESET_PC;
            fetch_addr_q   <= RESET_PC & ~ADDR_W'(7);
            req_addr_q     <= RESET_PC & ~ADDR_W'(7);
            req_q          <= 1'b0;
            drop_pending_q <= 1'b0;
            skip_first_q   <= RESET_PC[2];
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            head_pc_q      <= head_pc_d;
            fetch_addr_q   <= fetch_addr_d;
            req_addr_q     <= req_addr_d;
            req_q          <= req_d;
            drop_pending_q <= drop_pending_d;
            skip_first_q   <= skip_first_d;
        end
    end

    // Outputs come straight from registered state; invalid slots read as zero.
    assign imem_req  = req_q;
    assign imem_addr = req_addr_q;
    assign valid0    = (count_q >= CNT_W'(1));
    assign valid1    = (count_q >= CNT_W'(2));
    assign instr0    = valid0 ? mem_q[rd_ptr_q]     : '0;
    assign instr1    = valid1 ? mem_q[rd_ptr_nxt_s] : '0;
    assign pc0       = head_pc_q;

`ifdef SPU_FETCH_PERF_EN
    logic [31:0] perf_empty_q, perf_empty_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    // Performance counter next-state (both wrap freely)
    always_comb begin
        perf_empty_d = perf_empty_q;
        perf_redir_d = perf_redir_q;
        if (!valid0) begin
            perf_empty_d = perf_empty_q + 32'd1;
        end else begin
            perf_empty_d = perf_empty_q;
        end
        if (redirect) begin
            perf_redir_d = perf_redir_q + 32'd1;
        end else begin
            perf_redir_d = perf_redir_q;
        end
    end

    // Performance counter registers; held at zero while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_empty_q <= 32'd0;
            perf_redir_q <= 32'd0;
        end else begin
            perf_empty_q <= perf_empty_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_empty_cnt    = perf_empty_q;
    assign perf_redirect_cnt = perf_redir_q;
`endif

endmodule
